// File: rtl/wb_except_ctrl.sv
// Writeback-stage commit and exception controller.
// Latches the retiring instruction, resolves its exception cause by fixed
// priority, drives the CSR file's exception/ertn inputs and gated write
// ports, then holds a fetch redirect until IF accepts it.
module wb_except_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic [31:0] ms_vaddr,
  input  logic [5:0]  ms_ex,
  input  logic        ms_ertn,
  input  logic        ms_rf_we,
  input  logic [4:0]  ms_rf_waddr,
  input  logic [31:0] ms_rf_wdata,
  input  logic        ms_csr_we,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_csr_wmask,
  input  logic [31:0] ms_csr_wvalue,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        ertn_flush,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  typedef enum logic {RUN, REDIR} state_t;

  state_t      state_q, state_d;
  logic        ws_valid_q, ws_valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic [5:0]  ex_q, ex_d;
  logic        ertn_q, ertn_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        csr_we_q, csr_we_d;
  logic [13:0] csr_num_q, csr_num_d;
  logic [31:0] csr_wmask_q, csr_wmask_d;
  logic [31:0] csr_wvalue_q, csr_wvalue_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic ex_any;
  logic do_ertn;

  assign ex_any  = ws_valid_q && (|ex_q);
  assign do_ertn = ws_valid_q && ertn_q && !ex_any;

  // Next-state: instruction latch, redirect capture and FSM transitions.
  // A committing exception/ertn wins over a same-cycle MEM handoff: that
  // younger instruction is being flushed, so it is never latched.
  always_comb begin
    state_d       = state_q;
    ws_valid_d    = ws_valid_q;
    pc_d          = pc_q;
    vaddr_d       = vaddr_q;
    ex_d          = ex_q;
    ertn_d        = ertn_q;
    rf_we_d       = rf_we_q;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    csr_we_d      = csr_we_q;
    csr_num_d     = csr_num_q;
    csr_wmask_d   = csr_wmask_q;
    csr_wvalue_d  = csr_wvalue_q;
    redirect_pc_d = redirect_pc_q;
    unique case (state_q)
      RUN: begin
        if (ex_any || do_ertn) begin
          state_d       = REDIR;
          ws_valid_d    = 1'b0;
          redirect_pc_d = ex_any ? csr_eentry : csr_era;
        end else if (ms_to_ws_valid) begin
          ws_valid_d   = 1'b1;
          pc_d         = ms_pc;
          vaddr_d      = ms_vaddr;
          ex_d         = ms_ex;
          ertn_d       = ms_ertn;
          rf_we_d      = ms_rf_we;
          rf_waddr_d   = ms_rf_waddr;
          rf_wdata_d   = ms_rf_wdata;
          csr_we_d     = ms_csr_we;
          csr_num_d    = ms_csr_num;
          csr_wmask_d  = ms_csr_wmask;
          csr_wvalue_d = ms_csr_wvalue;
        end else begin
          ws_valid_d = 1'b0;
        end
      end
      REDIR: begin
        ws_valid_d = 1'b0;
        if (redirect_ready) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State and latched-instruction registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= RUN;
      ws_valid_q    <= 1'b0;
      pc_q          <= '0;
      vaddr_q       <= '0;
      ex_q          <= '0;
      ertn_q        <= 1'b0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      csr_we_q      <= 1'b0;
      csr_num_q     <= '0;
      csr_wmask_q   <= '0;
      csr_wvalue_q  <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      ws_valid_q    <= ws_valid_d;
      pc_q          <= pc_d;
      vaddr_q       <= vaddr_d;
      ex_q          <= ex_d;
      ertn_q        <= ertn_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      csr_we_q      <= csr_we_d;
      csr_num_q     <= csr_num_d;
      csr_wmask_q   <= csr_wmask_d;
      csr_wvalue_q  <= csr_wvalue_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Outputs: cause priority decode, gated commit strobes, redirect request.
  always_comb begin
    wb_ecode    = '0;
    wb_esubcode = '0;
    wb_vaddr    = '0;
    if (ex_any) begin
      if (ex_q[0]) begin
        wb_ecode = 6'h00;
      end else if (ex_q[1]) begin
        wb_ecode = 6'h08;
        wb_vaddr = pc_q;
      end else if (ex_q[2]) begin
        wb_ecode = 6'h0D;
      end else if (ex_q[3]) begin
        wb_ecode = 6'h0B;
      end else if (ex_q[4]) begin
        wb_ecode = 6'h0C;
      end else begin
        wb_ecode = 6'h09;
        wb_vaddr = vaddr_q;
      end
    end
    ws_allowin     = (state_q == RUN);
    wb_ex          = (state_q == RUN) && ex_any;
    ertn_flush     = (state_q == RUN) && do_ertn;
    rf_we          = (state_q == RUN) && ws_valid_q && rf_we_q && !ex_any;
    csr_we         = (state_q == RUN) && ws_valid_q && csr_we_q && !ex_any;
    pipe_flush     = ((state_q == RUN) && (ex_any || do_ertn)) || (state_q == REDIR);
    redirect_valid = (state_q == REDIR);
    redirect_pc    = redirect_pc_q;
    wb_pc          = pc_q;
    rf_waddr       = rf_waddr_q;
    rf_wdata       = rf_wdata_q;
    csr_num        = csr_num_q;
    csr_wmask      = csr_wmask_q;
    csr_wvalue     = csr_wvalue_q;
  end

endmodule

// File: tb/tb_wb_except_ctrl.sv
// Directed bench for wb_except_ctrl: commit, exception priority, ertn,
// redirect handshake and reset during a pending redirect.
module tb_wb_except_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc, ms_vaddr;
  logic [5:0]  ms_ex;
  logic        ms_ertn;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_rf_wdata;
  logic        ms_csr_we;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_csr_wmask, ms_csr_wvalue;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr;
  logic        ertn_flush;
  logic [31:0] csr_eentry, csr_era;
  logic        pipe_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  wb_except_ctrl dut (
    .clk(clk), .resetn(resetn),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_vaddr(ms_vaddr), .ms_ex(ms_ex), .ms_ertn(ms_ertn),
    .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
    .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num),
    .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
    .csr_eentry(csr_eentry), .csr_era(csr_era),
    .pipe_flush(pipe_flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ms();
    ms_to_ws_valid = 1'b0;
    ms_pc = '0; ms_vaddr = '0; ms_ex = '0; ms_ertn = 1'b0;
    ms_rf_we = 1'b0; ms_rf_waddr = '0; ms_rf_wdata = '0;
    ms_csr_we = 1'b0; ms_csr_num = '0; ms_csr_wmask = '0; ms_csr_wvalue = '0;
  endtask

  // Present one instruction for a single cycle; returns with it latched.
  task automatic issue(input logic [31:0] pc, input logic [5:0] ex, input logic ertn,
                       input logic [31:0] vaddr, input logic rfw, input logic [4:0] wa,
                       input logic [31:0] wd);
    ms_to_ws_valid = 1'b1;
    ms_pc = pc; ms_ex = ex; ms_ertn = ertn; ms_vaddr = vaddr;
    ms_rf_we = rfw; ms_rf_waddr = wa; ms_rf_wdata = wd;
    ms_csr_we = 1'b1; ms_csr_num = 14'h6; ms_csr_wmask = 32'hffff_ffff; ms_csr_wvalue = 32'h55;
    tick();
    clear_ms();
  endtask

  // Exception priority table: flags, pc, vaddr, expected ecode and wb_vaddr.
  typedef struct {
    logic [5:0]  ex;
    logic [31:0] pc;
    logic [31:0] va;
    logic [5:0]  ecode;
    logic [31:0] evaddr;
  } exv_t;

  exv_t exv[5];

  initial begin
    exv[0] = '{6'b100010, 32'h1c000003, 32'h8,  6'h08, 32'h1c000003};
    exv[1] = '{6'b100000, 32'h1c000020, 32'h13, 6'h09, 32'h13};
    exv[2] = '{6'b110100, 32'h1c000024, 32'h4,  6'h0D, 32'h0};
    exv[3] = '{6'b110000, 32'h1c000028, 32'h4,  6'h0C, 32'h0};
    exv[4] = '{6'b011001, 32'h1c00002c, 32'h4,  6'h00, 32'h0};

    clear_ms();
    resetn = 1'b0;
    redirect_ready = 1'b0;
    csr_eentry = 32'h1c008000;
    csr_era = 32'h0;
    tick(); tick();
    resetn = 1'b1;

    // Reset state
    chk("rst_allowin", 32'(ws_allowin), 32'd1);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_wb_ex", 32'(wb_ex), 32'd0);
    chk("rst_csr_we", 32'(csr_we), 32'd0);
    chk("rst_flush", 32'(pipe_flush), 32'd0);
    chk("rst_rvalid", 32'(redirect_valid), 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_wb_pc", wb_pc, 32'd0);

    // Plain add retires one cycle later, single-cycle pulse
    issue(32'h1c000000, 6'b0, 1'b0, 32'h0, 1'b1, 5'd5, 32'h1234);
    chk("add_rf_we", 32'(rf_we), 32'd1);
    chk("add_waddr", 32'(rf_waddr), 32'd5);
    chk("add_wdata", rf_wdata, 32'h1234);
    chk("add_csr_we", 32'(csr_we), 32'd1);
    chk("add_wb_ex", 32'(wb_ex), 32'd0);
    chk("add_flush", 32'(pipe_flush), 32'd0);
    chk("add_wb_pc", wb_pc, 32'h1c000000);
    tick();
    chk("add_rf_we_off", 32'(rf_we), 32'd0);

    // Back-to-back retirement
    ms_to_ws_valid = 1'b1; ms_rf_we = 1'b1; ms_rf_waddr = 5'd1; ms_rf_wdata = 32'hA1;
    tick();
    chk("b2b0_allowin", 32'(ws_allowin), 32'd1);
    chk("b2b0_wdata", rf_wdata, 32'hA1);
    ms_rf_waddr = 5'd2; ms_rf_wdata = 32'hB2;
    tick();
    clear_ms();
    chk("b2b1_rf_we", 32'(rf_we), 32'd1);
    chk("b2b1_waddr", 32'(rf_waddr), 32'd2);
    chk("b2b1_wdata", rf_wdata, 32'hB2);
    chk("b2b1_allowin", 32'(ws_allowin), 32'd1);
    tick();

    // SYS with redirect held off for three cycles
    issue(32'h1c000010, 6'b001000, 1'b0, 32'h0, 1'b1, 5'd7, 32'h77);
    chk("sys_wb_ex", 32'(wb_ex), 32'd1);
    chk("sys_ecode", 32'(wb_ecode), 32'h0B);
    chk("sys_esub", 32'(wb_esubcode), 32'd0);
    chk("sys_wb_pc", wb_pc, 32'h1c000010);
    chk("sys_csr_we", 32'(csr_we), 32'd0);
    chk("sys_rf_we", 32'(rf_we), 32'd0);
    chk("sys_flush", 32'(pipe_flush), 32'd1);
    chk("sys_rvalid_early", 32'(redirect_valid), 32'd0);
    tick();
    csr_eentry = 32'hdead0000;
    for (int i = 0; i < 3; i++) begin
      chk("sys_rvalid", 32'(redirect_valid), 32'd1);
      chk("sys_rpc", redirect_pc, 32'h1c008000);
      chk("sys_allowin", 32'(ws_allowin), 32'd0);
      chk("sys_redir_flush", 32'(pipe_flush), 32'd1);
      chk("sys_redir_wb_ex", 32'(wb_ex), 32'd0);
      tick();
    end
    chk("sys_rvalid_hold", 32'(redirect_valid), 32'd1);
    redirect_ready = 1'b1;
    csr_eentry = 32'h1c008000;
    tick();
    chk("sys_release_rvalid", 32'(redirect_valid), 32'd0);
    chk("sys_release_allowin", 32'(ws_allowin), 32'd1);
    chk("sys_release_flush", 32'(pipe_flush), 32'd0);

    // Priority table, redirect_ready held high: REDIR lasts one cycle
    foreach (exv[k]) begin
      issue(exv[k].pc, exv[k].ex, 1'b0, exv[k].va, 1'b0, 5'd0, 32'h0);
      chk("pri_wb_ex", 32'(wb_ex), 32'd1);
      chk("pri_ecode", 32'(wb_ecode), 32'(exv[k].ecode));
      chk("pri_esub", 32'(wb_esubcode), 32'd0);
      chk("pri_vaddr", wb_vaddr, exv[k].evaddr);
      tick();
      chk("pri_rvalid", 32'(redirect_valid), 32'd1);
      chk("pri_rpc", redirect_pc, 32'h1c008000);
      tick();
      chk("pri_back_run", 32'(ws_allowin), 32'd1);
    end

    // ERTN
    csr_era = 32'h1c000040;
    issue(32'h1c000030, 6'b0, 1'b1, 32'h0, 1'b1, 5'd3, 32'h3);
    chk("ertn_flush", 32'(ertn_flush), 32'd1);
    chk("ertn_wb_ex", 32'(wb_ex), 32'd0);
    chk("ertn_pflush", 32'(pipe_flush), 32'd1);
    chk("ertn_rf_we", 32'(rf_we), 32'd1);
    tick();
    chk("ertn_flush_off", 32'(ertn_flush), 32'd0);
    chk("ertn_rvalid", 32'(redirect_valid), 32'd1);
    chk("ertn_rpc", redirect_pc, 32'h1c000040);
    tick();

    // ERTN together with INT: exception wins
    issue(32'h1c000034, 6'b000001, 1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("ertnint_wb_ex", 32'(wb_ex), 32'd1);
    chk("ertnint_ecode", 32'(wb_ecode), 32'd0);
    chk("ertnint_flush", 32'(ertn_flush), 32'd0);
    tick();
    chk("ertnint_rpc", redirect_pc, 32'h1c008000);
    tick();

    // Reset during a pending redirect
    redirect_ready = 1'b0;
    issue(32'h1c000050, 6'b010000, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("rr_rvalid_before", 32'(redirect_valid), 32'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rr_rvalid", 32'(redirect_valid), 32'd0);
    chk("rr_allowin", 32'(ws_allowin), 32'd1);
    chk("rr_rpc", redirect_pc, 32'd0);
    issue(32'h1c000060, 6'b0, 1'b0, 32'h0, 1'b1, 5'd9, 32'h99);
    chk("rr_rf_we", 32'(rf_we), 32'd1);
    chk("rr_waddr", 32'(rf_waddr), 32'd9);
    chk("rr_wdata", rf_wdata, 32'h99);
    chk("rr_wb_ex", 32'(wb_ex), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_except_ctrl.md
# wb_except_ctrl

Writeback-stage commit and exception controller. It sits between the MEM stage and the CSR file. It latches the retiring instruction, resolves its exception flags by fixed priority, and drives the CSR file's exception/ertn inputs and gated CSR/GPR write ports. It then holds a fetch-redirect request (to `CSR.EENTRY` or `CSR.ERA`) until the IF stage accepts it, flushing younger stages meanwhile.

## Interface
- No parameters.
- `clk`  in  1  clock; all state updates on rising edge.
- `resetn`  in  1  reset; synchronous, active-low.
- `ms_to_ws_valid`  in  1  MEM has an instruction for WB.
- `ws_allowin`  out  1  WB accepts an instruction this cycle.
- `ms_pc`  in  32  instruction PC.
- `ms_vaddr`  in  32  data address (used for ALE).
- `ms_ex`  in  6  exception flags: [0] INT, [1] ADEF, [2] INE, [3] SYS, [4] BRK, [5] ALE.
- `ms_ertn`  in  1  instruction is ERTN.
- `ms_rf_we`, `ms_rf_waddr`, `ms_rf_wdata`  in  1/5/32  GPR write.
- `ms_csr_we`, `ms_csr_num`, `ms_csr_wmask`, `ms_csr_wvalue`  in  1/14/32/32  CSR write.
- `rf_we`, `rf_waddr`, `rf_wdata`  out  1/5/32  GPR write port.
- `csr_we`, `csr_num`, `csr_wmask`, `csr_wvalue`  out  1/14/32/32  to CSR file.
- `wb_ex`, `wb_ecode`, `wb_esubcode`, `wb_pc`, `wb_vaddr`  out  1/6/9/32/32  to CSR file.
- `ertn_flush`  out  1  to CSR file.
- `csr_eentry`, `csr_era`  in  32/32  current CSR values.
- `pipe_flush`  out  1  invalidate IF/ID/EX/MEM contents.
- `redirect_valid`  out  1  fetch redirect request.
- `redirect_pc`  out  32  redirect target.
- `redirect_ready`  in  1  IF accepts redirect.

## Operation
- State: `RUN`, `REDIR`. Registers: `ws_valid`, latched MEM fields, `redirect_pc`.
- `ws_allowin = (state==RUN)`. On `ms_to_ws_valid && ws_allowin`, latch all `ms_*` fields and set `ws_valid=1`. Otherwise, in `RUN`, set `ws_valid=0`.
- `ex_any = ws_valid && |ex`. `do_ertn = ws_valid && ertn && !ex_any`.
- Priority (highest first):
  - INT: ecode 0x00, sub 0.
  - ADEF: 0x08, sub 0.
  - INE: 0x0D.
  - SYS: 0x0B.
  - BRK: 0x0C.
  - ALE: 0x09.
  - Esubcode is 0 for every cause except where noted.
- `wb_vaddr` = pc for ADEF, latched vaddr for ALE, else 0. `wb_pc` = latched pc.
- Outputs in `RUN` only:
  - `wb_ex = ex_any`.
  - `ertn_flush = do_ertn`.
  - `rf_we = ws_valid && rf_we_l && !ex_any`.
  - `csr_we = ws_valid && csr_we_l && !ex_any`.
  - Address/data outputs pass latched values.
- `RUN -> REDIR` when `ex_any || do_ertn`. In that same edge:
  - latch `redirect_pc = ex_any ? csr_eentry : csr_era`, using pre-edge CSR values;
  - clear `ws_valid`.
- `REDIR`:
  - `redirect_valid=1`.
  - `ws_allowin=0`.
  - `wb_ex`, `ertn_flush`, `rf_we`, `csr_we` are 0.
  - Go to `RUN` on `redirect_valid && redirect_ready` edge.
- `pipe_flush = (state==RUN && (ex_any||do_ertn)) || state==REDIR`.
- Reset values:
  - State `RUN`.
  - `ws_valid=0`, `redirect_pc=0`, all latched fields 0.
  - Hence all outputs 0 except `ws_allowin=1`.
- Reset mid-`REDIR`: the request is dropped; next cycle is `RUN` with `redirect_valid=0`.

## Timing
- Instruction latched at edge N. Exception/ertn/write outputs are combinational from registers during cycle N+1 and last exactly one cycle.
- `redirect_valid` rises in cycle N+2 and holds with a stable `redirect_pc` until the handshake. With `redirect_ready` already high, `REDIR` lasts exactly 1 cycle.
- First new instruction can be accepted in the cycle after the handshake edge.
- Back-to-back non-excepting instructions: one retirement per cycle, `ws_allowin` constantly 1.
- `ms_ex` with multiple bits set: only the highest-priority cause is reported. ERTN with any exception: exception wins, `ertn_flush=0`.

## Test plan
- After reset: `ws_allowin=1`, every other output 0. Feed an add: pc 0x1c000000, `rf_we=1`, waddr 5, wdata 0x1234. Required: `rf_we` pulses one cycle later with these values, `wb_ex=0`, `pipe_flush=0`.
- SYS with `csr_eentry=0x1c008000`, pc 0x1c000010, `ms_csr_we=1`. Required:
  - `wb_ex=1`, ecode 0x0B, `wb_pc=0x1c000010`, `csr_we=0`, `pipe_flush=1`;
  - `redirect_valid=1`, `redirect_pc=0x1c008000`;
  - `redirect_ready` held low 3 cycles: request held stable, `ws_allowin=0`; released after the handshake.
- `ms_ex=6'b100010` (ADEF+ALE), pc 0x1c000003, vaddr 0x8. Required: ecode 0x08, esubcode 0, `wb_vaddr=0x1c000003`.
- ERTN with `csr_era=0x1c000040`. Required: `ertn_flush=1` for one cycle, `wb_ex=0`, `redirect_pc=0x1c000040`. ERTN plus INT flag: `wb_ex=1`, ecode 0, `ertn_flush=0`, target `eentry`.
- Assert `resetn=0` for one cycle while in `REDIR`. Required: next cycle `redirect_valid=0`, `ws_allowin=1`. A following instruction retires normally.
